// File: rtl/mult4_mac_pkg.sv
// Shared types and constants for the mult4 multiply-accumulate datapath.
package mult4_mac_pkg;

    localparam int PROD_W = 8;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } mac_state_e;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        int t;
        r = 0;
        t = v - 1;
        while (t > 0) begin
            r++;
            t = t >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult4_mac_if.sv
// Product-in / result-out handshake bundle for mult4_mac_accum, plus the synchronous abort.
interface mult4_mac_if #(
    parameter int ACC_W = 10
);
    import mult4_mac_pkg::*;

    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output clr, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  clr, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/mult4_mac_add.sv
// Accumulate adder with carry-out; MULT4_MAC_SAT_EN selects clamp-to-max instead of wrap.
module mult4_mac_add
    import mult4_mac_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              ovf_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
    assign ovf_o = ovf_i | wide[ACC_W];

`ifdef MULT4_MAC_SAT_EN
    // Once the block has overflowed the sum stays pinned at full scale.
    assign sum_o = ovf_o ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    assign sum_o = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult4_mac_accum.sv
// Streaming accumulator: sums N_TERMS products per block, presents result under valid/ready.
module mult4_mac_accum
    import mult4_mac_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    mult4_mac_if.slave     bus
);

    localparam int              CNT_W = (clog2(N_TERMS + 1) < 1) ? 1 : clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    mac_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    mult4_mac_add #(.ACC_W(ACC_W)) u_add (
        .acc_i  (acc_q),
        .prod_i (bus.in_prod),
        .ovf_i  (ovf_q),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;

        // clr wins over both handshakes; the product offered this cycle is dropped.
        if (bus.clr) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (bus.in_valid) begin
                        acc_d = add_sum;
                        ovf_d = add_ovf;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_d   = DONE;
                            out_sum_d = add_sum;
                            out_ovf_d = add_ovf;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult4_mac_accum.sv
// Scoreboard bench for mult4_mac_accum: ACC_W=10 instance for the main flow, ACC_W=9 for overflow.
module tb_mult4_mac_accum;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    logic [10:0] exp10_q[$];
    logic [9:0]  exp9_q[$];

    mult4_mac_if #(.ACC_W(10)) b10 ();
    mult4_mac_if #(.ACC_W(9))  b9 ();

    mult4_mac_accum #(.N_TERMS(4), .ACC_W(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10));
    mult4_mac_accum #(.N_TERMS(4), .ACC_W(9))  dut9  (.clk(clk), .rst_n(rst_n), .bus(b9));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer one product and return at the negedge following its acceptance.
    task automatic push(input int sel, input logic [7:0] p);
        int n;
        n = 0;
        if (sel == 0) begin b10.in_valid = 1'b1; b10.in_prod = p; end
        else          begin b9.in_valid  = 1'b1; b9.in_prod  = p; end
        while (((sel == 0) ? b10.in_ready : b9.in_ready) == 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept_in_time", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        if (sel == 0) b10.in_valid = 1'b0;
        else          b9.in_valid  = 1'b0;
    endtask

    // Monitors sample between edges, after stimulus driven at the negedge has settled.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && b10.out_valid && b10.out_ready) begin
            if (exp10_q.size() == 0) begin
                chk("sb10_unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [10:0] e;
                e = exp10_q.pop_front();
                chk("sb10_sum", 32'(b10.out_sum), 32'(e[9:0]));
                chk("sb10_ovf", 32'(b10.out_ovf), 32'(e[10]));
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (rst_n && b9.out_valid && b9.out_ready) begin
            if (exp9_q.size() == 0) begin
                chk("sb9_unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [9:0] e;
                e = exp9_q.pop_front();
                chk("sb9_sum", 32'(b9.out_sum), 32'(e[8:0]));
                chk("sb9_ovf", 32'(b9.out_ovf), 32'(e[9]));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        b10.clr = 1'b0; b10.in_valid = 1'b0; b10.in_prod = '0; b10.out_ready = 1'b1;
        b9.clr  = 1'b0; b9.in_valid  = 1'b0; b9.in_prod  = '0; b9.out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("reset_in_ready",  32'(b10.in_ready),  32'd1);
        chk("reset_out_valid", 32'(b10.out_valid), 32'd0);
        chk("reset_out_sum",   32'(b10.out_sum),   32'd0);
        chk("reset_out_ovf",   32'(b10.out_ovf),   32'd0);

        // Back-to-back block, result visible exactly one cycle.
        exp10_q.push_back({1'b0, 10'd900});
        for (int i = 0; i < 4; i++) push(0, 8'd225);
        chk("b2b_out_valid_rise", 32'(b10.out_valid), 32'd1);
        chk("b2b_in_ready_low",   32'(b10.in_ready),  32'd0);
        @(negedge clk);
        chk("b2b_out_valid_fall", 32'(b10.out_valid), 32'd0);
        chk("b2b_in_ready_back",  32'(b10.in_ready),  32'd1);

        // Consumer stalls for 5 cycles while a product waits upstream.
        b10.out_ready = 1'b0;
        exp10_q.push_back({1'b0, 10'd10});
        push(0, 8'd1); push(0, 8'd2); push(0, 8'd3); push(0, 8'd4);
        b10.in_valid = 1'b1;
        b10.in_prod  = 8'd3;
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(b10.out_valid), 32'd1);
            chk("stall_in_ready",  32'(b10.in_ready),  32'd0);
            chk("stall_out_sum",   32'(b10.out_sum),   32'd10);
            @(negedge clk);
        end
        b10.out_ready = 1'b1;
        exp10_q.push_back({1'b0, 10'd18});
        push(0, 8'd3); push(0, 8'd5); push(0, 8'd5); push(0, 8'd5);
        @(negedge clk);

        // Asynchronous reset between edges drops the partial block.
        push(0, 8'd10); push(0, 8'd20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready",  32'(b10.in_ready),  32'd1);
        chk("async_rst_out_valid", 32'(b10.out_valid), 32'd0);
        chk("async_rst_out_sum",   32'(b10.out_sum),   32'd0);
        chk("async_rst_out_ovf",   32'(b10.out_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp10_q.push_back({1'b0, 10'd10});
        push(0, 8'd1); push(0, 8'd2); push(0, 8'd3); push(0, 8'd4);
        @(negedge clk);

        // clr in ACC drops the partial sum and the product offered alongside it.
        push(0, 8'd50); push(0, 8'd60);
        b10.clr = 1'b1; b10.in_valid = 1'b1; b10.in_prod = 8'd70;
        @(negedge clk);
        b10.clr = 1'b0; b10.in_valid = 1'b0;
        exp10_q.push_back({1'b0, 10'd4});
        for (int i = 0; i < 4; i++) push(0, 8'd1);
        @(negedge clk);

        // clr in DONE discards the pending result.
        b10.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(0, 8'd9);
        chk("clr_done_valid_before", 32'(b10.out_valid), 32'd1);
        b10.clr = 1'b1;
        @(negedge clk);
        b10.clr = 1'b0;
        chk("clr_done_valid_after", 32'(b10.out_valid), 32'd0);
        chk("clr_done_in_ready",    32'(b10.in_ready),  32'd1);
        b10.out_ready = 1'b1;

        // Gaps in in_valid stall accumulation without losing count.
        exp10_q.push_back({1'b0, 10'd263});
        begin
            logic [7:0] gp [4];
            gp[0] = 8'd7; gp[1] = 8'd0; gp[2] = 8'd255; gp[3] = 8'd1;
            for (int i = 0; i < 4; i++) begin
                push(0, gp[i]);
                if (i < 3) begin
                    int g;
                    g = $urandom_range(1, 3);
                    repeat (g) begin
                        chk("gap_no_early_result", 32'(b10.out_valid), 32'd0);
                        @(negedge clk);
                    end
                end
            end
        end
        @(negedge clk);

        // ACC_W=9 overflow: wrap or saturate, ovf sticky either way; next block starts clean.
`ifdef MULT4_MAC_SAT_EN
        exp9_q.push_back({1'b1, 9'd511});
`else
        exp9_q.push_back({1'b1, 9'd388});
`endif
        for (int i = 0; i < 4; i++) push(1, 8'd225);
        exp9_q.push_back({1'b0, 9'd10});
        push(1, 8'd1); push(1, 8'd2); push(1, 8'd3); push(1, 8'd4);

        repeat (5) @(negedge clk);
        chk("sb10_drained", 32'(exp10_q.size()), 32'd0);
        chk("sb9_drained",  32'(exp9_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
